flash_port_arbiter: RTL and testbench

Arbitrates and sequences the single 256-bit credential-flash port between two requesters: the Pass-Keeper core (requester 0: boot-load reads and encrypted-entry write-back) and the host/config link (requester 1: entry provisioning and readout). It grants one requester at a time, latches the command, drives the flash strobes for fixed read/write latencies, returns read data, and signals completion. It also rejects addresses beyond the populated range. It sits between the top-level core and the flash pins, replacing the core's direct `add_flash`/`write_data_flash`/`flash_write` connection.

---
 rtl/flash_port_arbiter.sv | 126 ++++++++++++
 tb/tb_flash_port_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter: round-robin arbiter and sequencer for the shared 256-bit credential flash port
// between the Pass-Keeper core (requester 0) and the host/config link (requester 1).
module flash_port_arbiter #(
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   max_address,
    input  logic         c_req,
    input  logic         c_we,
    input  logic [3:0]   c_addr,
    input  logic [255:0] c_wdata,
    input  logic         h_req,
    input  logic         h_we,
    input  logic [3:0]   h_addr,
    input  logic [255:0] h_wdata,
    output logic         c_gnt,
    output logic         h_gnt,
    output logic         c_done,
    output logic         h_done,
    output logic         err,
    output logic [255:0] rdata,
    output logic         busy,
    output logic [3:0]   fl_addr,
    output logic [255:0] fl_wdata,
    output logic         fl_re,
    output logic         fl_we,
    input  logic [255:0] fl_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic         last;
    logic         owner;
    logic         pick_h;
    logic         sel_we;
    logic [3:0]   sel_addr;
    logic [255:0] sel_wdata;

    // last = 1 means the host was served last, so the core wins a tie
    always_comb begin
        pick_h    = h_req & (~c_req | ~last);
        sel_we    = pick_h ? h_we : c_we;
        sel_addr  = pick_h ? h_addr : c_addr;
        sel_wdata = pick_h ? h_wdata : c_wdata;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            owner    <= 1'b0;
            c_gnt    <= 1'b0;
            h_gnt    <= 1'b0;
            c_done   <= 1'b0;
            h_done   <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            fl_addr  <= '0;
            fl_wdata <= '0;
            fl_re    <= 1'b0;
            fl_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (c_req | h_req) begin
                        owner    <= pick_h;
                        last     <= pick_h;
                        c_gnt    <= ~pick_h;
                        h_gnt    <= pick_h;
                        fl_addr  <= sel_addr;
                        fl_wdata <= sel_wdata;
                        if (sel_addr > max_address) begin
                            state  <= DONE;
                            err    <= 1'b1;
                            c_done <= ~pick_h;
                            h_done <= pick_h;
                        end else if (sel_we) begin
                            state <= WR;
                            fl_we <= 1'b1;
                            cnt   <= 4'(WR_LAT - 1);
                        end else begin
                            state <= RD;
                            fl_re <= 1'b1;
                            cnt   <= 4'(RD_LAT);
                        end
                    end
                end
                RD: begin
                    fl_re <= 1'b0;
                    if (cnt == 4'd0) begin
                        rdata  <= fl_rdata;
                        state  <= DONE;
                        c_done <= ~owner;
                        h_done <= owner;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR: begin
                    if (cnt == 4'd0) begin
                        fl_we  <= 1'b0;
                        state  <= DONE;
                        c_done <= ~owner;
                        h_done <= owner;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    c_done <= 1'b0;
                    h_done <= 1'b0;
                    err    <= 1'b0;
                    c_gnt  <= 1'b0;
                    h_gnt  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flash_port_arbiter.sv
// tb_flash_port_arbiter: directed checks of arbitration, read/write sequencing, range error and reset.
module tb_flash_port_arbiter;
    logic         clk;
    logic         rst;
    logic [3:0]   max_address;
    logic         c_req, c_we, h_req, h_we;
    logic [3:0]   c_addr, h_addr;
    logic [255:0] c_wdata, h_wdata, fl_rdata;
    logic         c_gnt, h_gnt, c_done, h_done, err, busy, fl_re, fl_we;
    logic [255:0] rdata, fl_wdata;
    logic [3:0]   fl_addr;
    int checks = 0;
    int errors = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_W  = {16{16'h1234}};
    localparam logic [255:0] PAT_X  = {16{16'hDEAD}};
    localparam logic [255:0] PAT_C  = {32{8'h3C}};

    flash_port_arbiter #(.RD_LAT(2), .WR_LAT(4)) dut (
        .clk(clk), .rst(rst), .max_address(max_address),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .c_gnt(c_gnt), .h_gnt(h_gnt), .c_done(c_done), .h_done(h_done),
        .err(err), .rdata(rdata), .busy(busy), .fl_addr(fl_addr),
        .fl_wdata(fl_wdata), .fl_re(fl_re), .fl_we(fl_we), .fl_rdata(fl_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; max_address = 4'd9;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = '0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = '0;
        fl_rdata = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {c_gnt, h_gnt}, 0);
        chk("rst_strobes", {fl_re, fl_we}, 0);
        chk("rst_rdata", rdata, 0);
        tick();
        rst = 1'b1;

        // core read at address 3
        c_req = 1; c_we = 0; c_addr = 3;
        tick();
        chk("rd_fl_re_c1", fl_re, 1);
        chk("rd_fl_addr_c1", fl_addr, 3);
        chk("rd_c_gnt_c1", c_gnt, 1);
        chk("rd_h_gnt_c1", h_gnt, 0);
        chk("rd_busy_c1", busy, 1);
        tick();
        chk("rd_fl_re_c2", fl_re, 0);
        chk("rd_c_gnt_c2", c_gnt, 1);
        tick();
        fl_rdata = PAT_A5;
        chk("rd_c_done_c3", c_done, 0);
        tick();
        chk("rd_c_done_c4", c_done, 1);
        chk("rd_rdata_c4", rdata, PAT_A5);
        chk("rd_h_gnt_c4", h_gnt, 0);
        chk("rd_err_c4", err, 0);
        c_req = 0; fl_rdata = '0;
        tick();
        chk("rd_c_done_c5", c_done, 0);
        chk("rd_busy_c5", busy, 0);
        chk("rd_c_gnt_c5", c_gnt, 0);
        chk("rd_rdata_hold", rdata, PAT_A5);

        // host write at address 7, wdata changes mid-transaction
        h_req = 1; h_we = 1; h_addr = 7; h_wdata = PAT_W;
        tick();
        chk("wr_fl_we_c1", fl_we, 1);
        chk("wr_h_gnt_c1", h_gnt, 1);
        chk("wr_fl_addr_c1", fl_addr, 7);
        chk("wr_fl_wdata_c1", fl_wdata, PAT_W);
        tick();
        h_wdata = PAT_X;
        chk("wr_fl_we_c2", fl_we, 1);
        tick();
        chk("wr_fl_we_c3", fl_we, 1);
        chk("wr_fl_wdata_c3", fl_wdata, PAT_W);
        tick();
        chk("wr_fl_we_c4", fl_we, 1);
        chk("wr_fl_addr_c4", fl_addr, 7);
        chk("wr_h_done_c4", h_done, 0);
        tick();
        chk("wr_fl_we_c5", fl_we, 0);
        chk("wr_h_done_c5", h_done, 1);
        chk("wr_c_done_c5", c_done, 0);
        chk("wr_fl_wdata_c5", fl_wdata, PAT_W);
        h_req = 0; h_we = 0;
        tick();
        chk("wr_h_done_c6", h_done, 0);
        chk("wr_busy_c6", busy, 0);

        // core read beyond max_address
        c_req = 1; c_we = 0; c_addr = 12;
        tick();
        chk("oor_c_done", c_done, 1);
        chk("oor_err", err, 1);
        chk("oor_fl_re", fl_re, 0);
        chk("oor_c_gnt", c_gnt, 1);
        c_req = 0;
        tick();
        chk("oor_err_clear", err, 0);
        chk("oor_busy", busy, 0);
        chk("oor_fl_re_after", fl_re, 0);
        chk("oor_rdata", rdata, PAT_A5);

        // reset in cycle 2 of a core write, then a fresh write
        c_req = 1; c_we = 1; c_addr = 5; c_wdata = PAT_C;
        tick();
        chk("rw_fl_we_c1", fl_we, 1);
        tick();
        #3 rst = 1'b0;
        #1;
        chk("rw_fl_we_rst", fl_we, 0);
        chk("rw_c_gnt_rst", c_gnt, 0);
        chk("rw_c_done_rst", c_done, 0);
        chk("rw_fl_wdata_rst", fl_wdata, 0);
        tick();
        chk("rw_c_done_in_rst", c_done, 0);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("rw_fl_we_c%0d", i), fl_we, 1);
            chk($sformatf("rw_c_gnt_c%0d", i), c_gnt, 1);
        end
        tick();
        chk("rw_fl_we_c5", fl_we, 0);
        chk("rw_c_done_c5", c_done, 1);
        chk("rw_fl_wdata", fl_wdata, PAT_C);
        c_req = 0; c_we = 0;
        tick();

        // fresh reset, then both requesters reading continuously
        rst = 1'b0;
        tick();
        rst = 1'b1;
        c_req = 1; c_we = 0; c_addr = 1;
        h_req = 1; h_we = 0; h_addr = 2;
        fl_rdata = PAT_C;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_c_gnt_%0d", i), c_gnt, (i % 2 == 0));
            chk($sformatf("rr_h_gnt_%0d", i), h_gnt, (i % 2 == 1));
            chk($sformatf("rr_fl_addr_%0d", i), fl_addr, (i % 2 == 0) ? 4'd1 : 4'd2);
            repeat (3) tick();
            chk($sformatf("rr_c_done_%0d", i), c_done, (i % 2 == 0));
            chk($sformatf("rr_h_done_%0d", i), h_done, (i % 2 == 1));
            repeat (2) tick();
        end
        chk("rr_rdata", rdata, PAT_C);
        c_req = 0; h_req = 0;
        repeat (5) tick();
        chk("rr_idle", busy, 0);

        // three back-to-back core reads
        c_req = 1; c_we = 0; c_addr = 2; fl_rdata = PAT_A5;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bb_gnt_%0d", i), c_gnt, 1);
            repeat (2) tick();
            chk($sformatf("bb_pre_done_%0d", i), c_done, 0);
            tick();
            chk($sformatf("bb_done_%0d", i), c_done, 1);
            if (i == 2) c_req = 0;
            tick();
            chk($sformatf("bb_idle_busy_%0d", i), busy, 0);
            chk($sformatf("bb_idle_done_%0d", i), c_done, 0);
            tick();
            chk($sformatf("bb_next_busy_%0d", i), busy, (i < 2));
        end
        chk("bb_rdata", rdata, PAT_A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
